// File: rtl/memristor_pkg.sv
// Shared types and helpers for the memristor PUF array and its challenge-side companions.
// Holds the FSM state type, the LFSR polynomial and the saturation helpers.
package memristor_pkg;

  typedef enum logic [2:0] {INIT, IDLE, POW, MUL, WB} state_t;

  localparam logic [15:0] LFSR_TAPS = 16'hB400;
  localparam int          WIDE_W    = 128;

  // One step of the right-shifting Galois LFSR.
  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return s[0] ? ((s >> 1) ^ LFSR_TAPS) : (s >> 1);
  endfunction

  // Magnitude of a w-bit signed value; the most negative code maps to the largest positive one.
  function automatic logic [31:0] sat_abs(input logic signed [31:0] v, input int w);
    longint lim;
    longint mag;
    lim = (longint'(1) <<< (w - 1)) - 1;
    mag = (v < 0) ? -longint'(v) : longint'(v);
    if (mag > lim) mag = lim;
    return 32'(mag);
  endfunction

  function automatic logic signed [WIDE_W-1:0] clamp(
    input logic signed [WIDE_W-1:0] v,
    input logic signed [WIDE_W-1:0] lo,
    input logic signed [WIDE_W-1:0] hi
  );
    if (v < lo) return lo;
    if (v > hi) return hi;
    return v;
  endfunction

endpackage

// File: rtl/memristor_puf_array_lfsr.sv
// 16-bit Galois LFSR with seed load on reset; also used by the challenge generator.
module puf_lfsr16
  import memristor_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] seed,
  input  logic        step,
  output logic [15:0] state
);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= seed;
    end else if (step) begin
      state <= lfsr_step(state);
    end
  end

endmodule

// File: rtl/memristor_puf_array.sv
// Array of behavioural memristor cells with per-cell c/vth variation, a multi-cycle
// |vin|^N_POWER write engine and a two-cell conductance-compare PUF read port.
module memristor_puf_array
  import memristor_pkg::*;
#(
  parameter int          NUM_CELLS    = 16,
  parameter int          VIN_WIDTH    = 16,
  parameter int          FRAC_BITS    = 8,
  parameter int          G_WIDTH      = 16,
  parameter int          G_FRAC_BITS  = 8,
  parameter int          N_POWER      = 2,
  parameter int          C_FRAC_BITS  = 12,
  parameter int          C_NOM        = 4096,
  parameter int          VTH_NOM      = 1024,
  parameter int          G_INIT       = 128,
  parameter int          G_MAX        = 32767,
  parameter int          C_VAR_BITS   = 10,
  parameter int          VTH_VAR_BITS = 6,
  parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
  input  logic                          clk,
  input  logic                          rst,
  output logic                          init_done,
  input  logic                          wr_valid,
  output logic                          wr_ready,
  input  logic [$clog2(NUM_CELLS)-1:0]  wr_addr,
  input  logic [VIN_WIDTH-1:0]          wr_vin,
  output logic                          wr_done,
  output logic                          wr_changed,
  input  logic                          rd_valid,
  input  logic [$clog2(NUM_CELLS)-1:0]  rd_addr_a,
  input  logic [$clog2(NUM_CELLS)-1:0]  rd_addr_b,
  output logic                          resp_valid,
  output logic                          resp_bit,
  output logic [G_WIDTH-1:0]            resp_g
);

  localparam int              AW       = $clog2(NUM_CELLS);
  localparam int              C_W      = C_FRAC_BITS + 4;
  localparam int              ACC_W    = VIN_WIDTH * N_POWER;
  localparam int              PROD_W   = C_W + ACC_W + 1;
  localparam int              VX_W     = VIN_WIDTH + 1;
  localparam int              SHIFT    = N_POWER * FRAC_BITS + C_FRAC_BITS - G_FRAC_BITS;
  localparam logic [AW-1:0]   LAST     = AW'(NUM_CELLS - 1);
  localparam logic [AW:0]     NCELLS   = (AW + 1)'(NUM_CELLS);
  localparam logic [2:0]      POW_LAST = 3'(N_POWER - 2);

  state_t                       state, state_nx;
  logic [AW-1:0]                idx;
  logic [15:0]                  lfsr, lfsr_nx;
  logic signed [C_W-1:0]        c_off;
  logic signed [VIN_WIDTH-1:0]  vth_off;

  logic signed [C_W-1:0]        c_arr   [NUM_CELLS];
  logic signed [VIN_WIDTH-1:0]  vth_arr [NUM_CELLS];
  logic signed [G_WIDTH-1:0]    g_arr   [NUM_CELLS];

  logic                         accept;
  logic [VIN_WIDTH-1:0]         vin_mag;
  logic [AW-1:0]                addr_p0;
  logic                         hit_p0;
  logic signed [VIN_WIDTH-1:0]  vin_p0;
  logic [VIN_WIDTH-1:0]         mag_p0;
  logic [ACC_W-1:0]             acc_p0;
  logic [2:0]                   pow_cnt;
  logic signed [G_WIDTH-1:0]    delta_p1;

  logic signed [C_W-1:0]        c_sel;
  logic signed [PROD_W-1:0]     prod;
  logic signed [VX_W-1:0]       vin_x, vth_x;
  logic                         up, dn;
  logic signed [WIDE_W-1:0]     g_cur, g_inc, g_dec;
  logic signed [G_WIDTH-1:0]    g_new;

  logic                         rd_hit_a, rd_hit_b;
  logic signed [G_WIDTH-1:0]    g_a, g_b;
  logic                         resp_valid_p1, resp_bit_p1;
  logic [G_WIDTH-1:0]           resp_g_p1;

  puf_lfsr16 u_lfsr (
    .clk   (clk),
    .rst   (rst),
    .seed  (LFSR_SEED),
    .step  (state == INIT),
    .state (lfsr)
  );

  // Cell i is built from the state the LFSR reaches on this cycle's step.
  assign lfsr_nx = lfsr_step(lfsr);

  generate
    if (C_VAR_BITS > 0) begin : g_cvar
      assign c_off = C_W'(signed'(lfsr_nx[C_VAR_BITS-1:0]));
    end else begin : g_cnom
      assign c_off = '0;
    end
    if (VTH_VAR_BITS > 0) begin : g_vvar
      assign vth_off = VIN_WIDTH'(signed'(lfsr_nx[15:16-VTH_VAR_BITS]));
    end else begin : g_vnom
      assign vth_off = '0;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= INIT;
      idx   <= '0;
    end else begin
      state <= state_nx;
      if (state == INIT) idx <= idx + 1'b1;
    end
  end

  always_comb begin
    state_nx   = state;
    init_done  = 1'b0;
    wr_ready   = 1'b0;
    wr_done    = 1'b0;
    wr_changed = 1'b0;
    if (!rst) begin
      init_done  = (state != INIT);
      wr_ready   = (state == IDLE);
      wr_done    = (state == WB);
      wr_changed = (state == WB) && (up || dn);
    end
    unique case (state)
      INIT:    if (idx == LAST) state_nx = IDLE;
      IDLE:    if (wr_valid) state_nx = (N_POWER > 1) ? POW : MUL;
      POW:     if (pow_cnt == POW_LAST) state_nx = MUL;
      MUL:     state_nx = WB;
      WB:      state_nx = IDLE;
      default: state_nx = INIT;
    endcase
  end

  assign accept  = wr_valid && wr_ready;
  assign vin_mag = VIN_WIDTH'(sat_abs(32'(signed'(wr_vin)), VIN_WIDTH));

  // p0: request latched, |vin| power accumulated in place
  always_ff @(posedge clk) begin
    if (accept) begin
      addr_p0 <= wr_addr;
      hit_p0  <= ({1'b0, wr_addr} < NCELLS);
      vin_p0  <= signed'(wr_vin);
      mag_p0  <= vin_mag;
      acc_p0  <= ACC_W'(vin_mag);
      pow_cnt <= '0;
    end else if (state == POW) begin
      acc_p0  <= ACC_W'(acc_p0 * ACC_W'(mag_p0));
      pow_cnt <= pow_cnt + 1'b1;
    end
  end

  assign c_sel = hit_p0 ? c_arr[addr_p0] : '0;
  assign prod  = PROD_W'(c_sel) * PROD_W'(signed'({1'b0, acc_p0}));

  // p1: scaled conductance step
  always_ff @(posedge clk) begin
    if (state == MUL) begin
      delta_p1 <= G_WIDTH'(clamp(WIDE_W'(prod >>> SHIFT), '0, WIDE_W'(G_MAX)));
    end
  end

  assign vin_x = VX_W'(vin_p0);
  assign vth_x = hit_p0 ? VX_W'(vth_arr[addr_p0]) : '0;
  assign up    = hit_p0 && (vin_x >= vth_x);
  assign dn    = hit_p0 && !up && (vin_x <= -vth_x);
  assign g_cur = hit_p0 ? WIDE_W'(g_arr[addr_p0]) : '0;
  assign g_inc = clamp(g_cur + WIDE_W'(delta_p1), '0, WIDE_W'(G_MAX));
  assign g_dec = clamp(g_cur - WIDE_W'(delta_p1), '0, WIDE_W'(G_MAX));
  assign g_new = up ? G_WIDTH'(g_inc) : G_WIDTH'(g_dec);

  // p2: cell initialisation and write-back
  always_ff @(posedge clk) begin
    if (state == INIT) begin
      c_arr[idx]   <= C_W'(C_NOM) + c_off;
      vth_arr[idx] <= VIN_WIDTH'(VTH_NOM) + vth_off;
      g_arr[idx]   <= G_WIDTH'(G_INIT);
    end else if (!rst && state == WB && (up || dn)) begin
      g_arr[addr_p0] <= g_new;
    end
  end

  assign rd_hit_a = ({1'b0, rd_addr_a} < NCELLS);
  assign rd_hit_b = ({1'b0, rd_addr_b} < NCELLS);
  assign g_a      = rd_hit_a ? g_arr[rd_addr_a] : '0;
  assign g_b      = rd_hit_b ? g_arr[rd_addr_b] : '0;

  // p1: read response, sampled before any same-cycle write-back lands
  always_ff @(posedge clk) begin
    if (rst) begin
      resp_valid_p1 <= 1'b0;
      resp_bit_p1   <= 1'b0;
      resp_g_p1     <= '0;
    end else begin
      resp_valid_p1 <= rd_valid && (state != INIT);
      if (rd_valid && state != INIT) begin
        resp_g_p1   <= g_a;
        resp_bit_p1 <= rd_hit_a && rd_hit_b && (rd_addr_a != rd_addr_b) && (g_a > g_b);
      end
    end
  end

  assign resp_valid = resp_valid_p1 && !rst;
  assign resp_bit   = resp_bit_p1 && !rst;
  assign resp_g     = rst ? '0 : resp_g_p1;

endmodule

// File: tb/tb_memristor_puf_array.sv
// Lockstep bench for a nominal 12-cell array and a default 16-cell array with variation,
// both checked against an arithmetic model of cell parameters and conductance updates.
module tb_memristor_puf_array;

  localparam int N0 = 12;
  localparam int N1 = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wr_valid = 1'b0;
  logic [3:0]  wr_addr = '0;
  logic [15:0] wr_vin = '0;
  logic        rd_valid = 1'b0;
  logic [3:0]  rd_addr_a = '0;
  logic [3:0]  rd_addr_b = '0;

  logic        init_done0, wr_ready0, wr_done0, wr_changed0, resp_valid0, resp_bit0;
  logic [15:0] resp_g0;
  logic        init_done1, wr_ready1, wr_done1, wr_changed1, resp_valid1, resp_bit1;
  logic [15:0] resp_g1;

  int checks = 0;
  int errors = 0;
  int c0 [16], vth0 [16], g0 [16];
  int c1 [16], vth1 [16], g1 [16];

  always #5 clk = ~clk;

  memristor_puf_array #(.NUM_CELLS(N0), .C_VAR_BITS(0), .VTH_VAR_BITS(0)) u_nom (
    .clk(clk), .rst(rst), .init_done(init_done0),
    .wr_valid(wr_valid), .wr_ready(wr_ready0), .wr_addr(wr_addr), .wr_vin(wr_vin),
    .wr_done(wr_done0), .wr_changed(wr_changed0),
    .rd_valid(rd_valid), .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
    .resp_valid(resp_valid0), .resp_bit(resp_bit0), .resp_g(resp_g0)
  );

  memristor_puf_array u_var (
    .clk(clk), .rst(rst), .init_done(init_done1),
    .wr_valid(wr_valid), .wr_ready(wr_ready1), .wr_addr(wr_addr), .wr_vin(wr_vin),
    .wr_done(wr_done1), .wr_changed(wr_changed1),
    .rd_valid(rd_valid), .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
    .resp_valid(resp_valid1), .resp_bit(resp_bit1), .resp_g(resp_g1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    checks++;
    assert (obs === want) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, want);
    end
  endtask

  function automatic logic [15:0] model_lfsr(input logic [15:0] s);
    return s[0] ? ((s >> 1) ^ 16'hB400) : (s >> 1);
  endfunction

  function automatic int sext(input int v, input int bits);
    return (v >= (1 << (bits - 1))) ? v - (1 << bits) : v;
  endfunction

  task automatic model_init();
    logic [15:0] s;
    s = 16'hACE1;
    for (int i = 0; i < 16; i++) begin
      s = model_lfsr(s);
      c0[i] = 4096; vth0[i] = 1024; g0[i] = 128;
      c1[i] = 4096 + sext(int'(s) & 1023, 10);
      vth1[i] = 1024 + sext(int'(s) >> 10, 6);
      g1[i] = 128;
    end
  endtask

  // g' from the pulse rules: delta = c*|vin|^2 / 2^(16+12-8), saturated to [0, 32767]
  function automatic int model_wb(input int g, input int c, input int vth, input int vin,
                                  output bit ch);
    longint mag, d, r;
    mag = (vin < 0) ? -longint'(vin) : longint'(vin);
    if (mag > 32767) mag = 32767;
    d = (longint'(c) * mag * mag) / (longint'(1) << 20);
    if (d > 32767) d = 32767;
    if (d < 0) d = 0;
    ch = 1'b0;
    r = g;
    if (vin >= vth) begin
      ch = 1'b1; r = g + d; if (r > 32767) r = 32767;
    end else if (vin <= -vth) begin
      ch = 1'b1; r = g - d; if (r < 0) r = 0;
    end
    return int'(r);
  endfunction

  function automatic int exp_g0(input int a);
    return (a < N0) ? g0[a] : 0;
  endfunction

  function automatic int exp_bit0(input int a, input int b);
    return (a < N0 && b < N0 && a != b && g0[a] > g0[b]) ? 1 : 0;
  endfunction

  task automatic check_resp(input int a, input int b);
    chk("resp_valid0", resp_valid0, 1);
    chk("resp_g0", resp_g0, exp_g0(a));
    chk("resp_bit0", resp_bit0, exp_bit0(a, b));
    chk("resp_valid1", resp_valid1, 1);
    chk("resp_g1", resp_g1, g1[a]);
    chk("resp_bit1", resp_bit1, (a != b && g1[a] > g1[b]) ? 1 : 0);
  endtask

  task automatic do_read(input int a, input int b);
    @(negedge clk);
    rd_valid = 1'b1; rd_addr_a = 4'(a); rd_addr_b = 4'(b);
    @(negedge clk);
    rd_valid = 1'b0;
    check_resp(a, b);
  endtask

  task automatic do_write(input int addr, input int vin, input bit rd_in_wb);
    int lat, e0, e1;
    bit ch0, ch1;
    @(negedge clk);
    chk("wr_ready0", wr_ready0, 1);
    chk("wr_ready1", wr_ready1, 1);
    wr_valid = 1'b1; wr_addr = 4'(addr); wr_vin = 16'(vin);
    @(negedge clk);
    wr_valid = 1'b0;
    lat = 1;
    while (!wr_done0 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk("wr_latency", lat, 3);
    chk("wr_done1", wr_done1, 1);
    e1 = model_wb(g1[addr], c1[addr], vth1[addr], vin, ch1);
    if (addr < N0) e0 = model_wb(g0[addr], c0[addr], vth0[addr], vin, ch0);
    else begin e0 = 0; ch0 = 1'b0; end
    chk("wr_changed0", wr_changed0, ch0);
    chk("wr_changed1", wr_changed1, ch1);
    if (rd_in_wb) begin
      rd_valid = 1'b1; rd_addr_a = 4'(addr); rd_addr_b = 4'(addr ^ 1);
    end
    @(negedge clk);
    chk("wr_done_pulse", wr_done0 | wr_done1, 0);
    if (rd_in_wb) begin
      rd_valid = 1'b0;
      check_resp(addr, addr ^ 1);
    end
    if (addr < N0) g0[addr] = e0;
    g1[addr] = e1;
  endtask

  task automatic do_reset();
    rst = 1'b1; wr_valid = 1'b0; rd_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_init_done", {init_done0, init_done1}, 0);
    chk("rst_wr_ready", {wr_ready0, wr_ready1}, 0);
    chk("rst_wr_done", {wr_done0, wr_done1}, 0);
    chk("rst_wr_changed", {wr_changed0, wr_changed1}, 0);
    chk("rst_resp_valid", {resp_valid0, resp_valid1}, 0);
    chk("rst_resp_bit", {resp_bit0, resp_bit1}, 0);
    chk("rst_resp_g0", resp_g0, 0);
    chk("rst_resp_g1", resp_g1, 0);
  endtask

  task automatic wait_init();
    int n, n0, n1;
    rst = 1'b0;
    n = 0; n0 = 0; n1 = 0;
    while (!(init_done0 && init_done1) && n < 100) begin
      @(negedge clk);
      n++;
      if (init_done0 && n0 == 0) n0 = n;
      if (init_done1 && n1 == 0) n1 = n;
      if (n == 1) begin
        rd_valid = 1'b1; rd_addr_a = 4'd1; rd_addr_b = 4'd2;
      end
      if (n == 2) begin
        rd_valid = 1'b0;
        chk("rd_dropped_in_init", {resp_valid0, resp_valid1}, 0);
      end
    end
    chk("init_cycles0", n0, N0);
    chk("init_cycles1", n1, N1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    model_init();
    do_reset();
    wait_init();

    do_write(3, 1280, 1'b0);
    do_read(3, 0);
    chk("g3_after_5V", resp_g0, 6528);

    do_write(4, 768, 1'b0);
    do_write(4, -768, 1'b0);
    do_read(4, 3);
    chk("g4_subthreshold", resp_g0, 128);

    do_write(5, -1280, 1'b0);
    do_read(5, 4);
    chk("g5_floor", resp_g0, 0);

    for (int k = 0; k < 6; k++) begin
      do_write(6, 1280, 1'b0);
      do_read(6, 5);
    end
    chk("g6_ceiling", resp_g0, 32767);

    do_write(7, -32768, 1'b0);
    do_read(7, 6);
    chk("g7_most_negative", resp_g0, 0);

    do_write(13, 1280, 1'b0);
    do_read(13, 14);
    do_read(3, 3);
    do_write(3, -1280, 1'b1);
    do_read(3, 6);

    for (int k = 0; k < 40; k++) begin
      int a, v, r;
      a = int'($urandom_range(0, 15));
      r = int'($urandom_range(0, 9));
      if (r == 0) v = -32768;
      else if (r < 4) v = int'($urandom_range(0, 2000)) - 1000;
      else begin
        v = int'($urandom_range(900, 1800));
        if ($urandom_range(0, 1) == 1) v = -v;
      end
      do_write(a, v, r == 5);
      do_read(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)));
    end

    // Abort a write in flight and rebuild the array.
    @(negedge clk);
    wr_valid = 1'b1; wr_addr = 4'd2; wr_vin = 16'd1280;
    @(negedge clk);
    wr_valid = 1'b0; rst = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("abort_no_wr_done", {wr_done0, wr_done1}, 0);
    end
    chk("abort_init_done_low", {init_done0, init_done1}, 0);
    do_reset();
    model_init();
    wait_init();
    for (int a = 0; a < 16; a++) do_read(a, (a + 1) % 16);
    for (int k = 0; k < 8; k++) begin
      do_write(k * 2, (k % 2 == 0) ? 1040 : -1040, 1'b0);
      do_read(k * 2, k * 2 + 1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/memristor_puf_array.md
Name: memristor_puf_array

Overview:
- Parametrised array of NUM_CELLS behavioural memristor cells. Each cell has its own fabrication-variation offsets on the rate constant c and the threshold vth, drawn from a seeded LFSR at initialisation.
- Cells are updated one at a time by addressed voltage-pulse writes using a valid/ready handshake. The write datapath is a small multi-cycle engine that computes |vin|^N_POWER.
- A read port compares two cells' conductances to produce a PUF response bit.
- Sits between the challenge/pulse generator and the response-collection logic.

Parameters:
- NUM_CELLS, 16, number of cells (≥2).
- VIN_WIDTH, 16, signed pulse-voltage width, Q(FRAC_BITS).
- FRAC_BITS, 8, vin fractional bits.
- G_WIDTH, 16, signed conductance width.
- G_FRAC_BITS, 8, conductance fractional bits.
- N_POWER, 2, nonlinearity exponent (1..6).
- C_FRAC_BITS, 12, fractional bits of c.
- C_NOM, 4096, nominal c (1.0).
- VTH_NOM, 1024, nominal threshold (4.0 V).
- G_INIT, 128, post-init conductance of every cell.
- G_MAX, 32767, upper conductance clamp.
- C_VAR_BITS, 10, width of the signed c offset. 0 means no variation.
- VTH_VAR_BITS, 6, width of the signed vth offset. 0 means no variation.
- LFSR_SEED, 16'hACE1, nonzero LFSR seed.

Ports:
- clk, in, 1, clock.
- rst, in, 1, synchronous active-high reset.
- init_done, out, 1, high once cell initialisation is complete.
- wr_valid, in, 1, pulse request valid.
- wr_ready, out, 1, engine can accept a pulse.
- wr_addr, in, $clog2(NUM_CELLS), target cell.
- wr_vin, in, VIN_WIDTH, signed pulse voltage.
- wr_done, out, 1, one-cycle pulse when the write-back completes.
- wr_changed, out, 1, qualified by wr_done; 1 if a threshold was crossed.
- rd_valid, in, 1, response request.
- rd_addr_a, in, $clog2(NUM_CELLS), first cell.
- rd_addr_b, in, $clog2(NUM_CELLS), second cell.
- resp_valid, out, 1, response valid.
- resp_bit, out, 1, g[a] > g[b].
- resp_g, out, G_WIDTH, g[a].

Behaviour:
- Reset:
  - Single clock. Reset is synchronous and active-high.
  - While rst is high: state=INIT, cell index 0, LFSR=LFSR_SEED.
  - All outputs are 0 during reset: init_done, wr_ready, wr_done, wr_changed, resp_valid, resp_bit, resp_g.
  - Reset mid-operation aborts any in-flight write without a wr_done. The array is fully re-initialised.
- LFSR: 16-bit Galois, taps 0xB400. It steps once per INIT cycle.
- INIT (NUM_CELLS cycles):
  - Cell i takes the LFSR state after i+1 steps.
  - c_off = sign-extended lfsr[C_VAR_BITS-1:0].
  - vth_off = sign-extended lfsr[15:16-VTH_VAR_BITS].
  - c[i] = C_NOM + c_off, vth[i] = VTH_NOM + vth_off, g[i] = G_INIT.
  - After the last cell, go to IDLE with init_done=1, which stays high until the next reset.
- IDLE:
  - wr_ready=1 only in IDLE.
  - On wr_valid&&wr_ready, latch addr and vin.
  - |vin| saturates, so -2^(VIN_WIDTH-1) maps to 2^(VIN_WIDTH-1)-1.
  - Next state: POW if N_POWER>1, else MUL.
- POW: N_POWER-1 cycles. Each cycle performs acc = acc*|vin| at full width VIN_WIDTH*N_POWER, unsigned magnitude.
- MUL (1 cycle):
  - prod = c[addr]*acc at full width.
  - delta = prod >>> (N_POWER*FRAC_BITS + C_FRAC_BITS - G_FRAC_BITS).
  - delta saturates to [0, G_MAX].
- WB (1 cycle):
  - If vin ≥ vth[addr]: g = min(g+delta, G_MAX).
  - If vin ≤ -vth[addr]: g = max(g-delta, 0).
  - Otherwise g is unchanged.
  - Pulse wr_done. wr_changed=1 only if a threshold was crossed.
  - Return to IDLE.
- Latency: accept to wr_done is N_POWER+1 cycles (3 at default). Back-to-back throughput is one write per N_POWER+2 cycles.
- Read port:
  - Accepted in any state except INIT; rd_valid during INIT is dropped.
  - resp_valid follows rd_valid by one cycle. resp_bit and resp_g are sampled from g at the request cycle.
  - A read in the same cycle as WB to the same cell returns the pre-update value.
  - If rd_addr_a==rd_addr_b, resp_bit=0.
  - Out-of-range addresses (NUM_CELLS not a power of 2): writes complete with wr_changed=0 and no state change. Reads return resp_bit=0, resp_g=0.
- Concurrency: reads and writes are independent and may occur in the same cycle.

Decomposition:
- Shared package memristor_pkg:
  - state enum {INIT, IDLE, POW, MUL, WB}.
  - LFSR tap constant.
  - sat_abs and clamp functions.
- Sub-module puf_lfsr16 (seed, step enable, state output), reusable by the challenge generator.
- Per-cell c/vth/g arrays stay in the top module.

Test Plan:
- C_VAR_BITS=VTH_VAR_BITS=0; after init, write cell 3 with vin=1280 (5.0 V) -> wr_done 3 cycles after accept, wr_changed=1, g[3]=128+6400=6528.
- Same config; vin=768 (3.0 V) then vin=-768 -> wr_changed=0 both times, g unchanged at 128.
- Same config; vin=-1280 on a fresh cell -> g clamps to 0, not -6272. Six +1280 pulses from 128 -> values 6528…32128, then 32767.
- vin=-32768 -> |vin| saturates to 32767, delta clamps to G_MAX, g=0. No X, no wrap.
- Default variation, seed 16'hACE1 -> per-cell c/vth match the golden LFSR model; read (a,b) gives resp_bit equal to model compare after identical pulse sequences. Read in the same cycle as WB of cell a returns the old g.
- Assert rst during POW -> no wr_done. init_done drops to 0, then returns high after NUM_CELLS cycles. All g back to 128, and the LFSR sequence repeats identically.
